// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Fetch stage of the single-cycle RISC-V core. Takes the current PC from the
// PC register, issues one request/grant/response read to instruction memory
// at a time, and buffers fetched words with their PCs in a small FIFO that
// decode drains through a valid/ready handshake. A branch/jump redirect
// flushes everything buffered and discards any response still in flight.
//
// Handshakes:
//   - pc_valid_i/pc_ack_o: the PC is taken in the cycle both are high;
//     pc_ack_o is combinational and only ever high in IDLE.
//   - imem_req_o/imem_gnt_i: once imem_req_o rises, it and imem_addr_o hold
//     until the cycle imem_gnt_i is high; a request is never withdrawn.
//   - instr_valid_o/instr_ready_i: the head entry transfers in the cycle
//     both are high; instr_* stay stable while valid is high and ready low.

module instr_fetch_unit #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    // PC register side
    input  logic [31:0] pc_i,
    input  logic        pc_valid_i,
    output logic        pc_ack_o,
    input  logic        redirect_i,
    // Instruction memory side
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    // Decode side
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_fault_o,
    input  logic        instr_ready_i,
    // FSM state for observation
    output logic [1:0]  dbg_state_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_next_state;
    logic              r_drop;
    logic              r_req;
    logic [31:0]       r_addr;

    logic [31:0]       r_fifo_instr [DEPTH];
    logic [31:0]       r_fifo_pc    [DEPTH];
    logic              r_fifo_fault [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic              w_busy;
    logic [CNT_W-1:0]  w_occupancy;
    logic              w_space;
    logic              w_ack;
    logic              w_aligned;
    logic              w_push_fault;
    logic              w_push_mem;
    logic              w_push;
    logic [31:0]       w_push_instr;
    logic [31:0]       w_push_pc;
    logic              w_valid;
    logic              w_pop;

    // A transaction in flight reserves one FIFO slot so its response always
    // has somewhere to land; the pre-pop count is used deliberately.
    assign w_busy       = (r_state != S_IDLE);
    assign w_occupancy  = r_count + {{(CNT_W-1){1'b0}}, w_busy};
    assign w_space      = (w_occupancy < DEPTH_C);
    assign w_aligned    = (pc_i[1:0] == 2'b00);
    assign w_ack        = (r_state == S_IDLE) & pc_valid_i & w_space & ~redirect_i;

    // Misaligned PCs never reach memory: a faulted NOP is pushed directly.
    assign w_push_fault = w_ack & ~w_aligned;
    // Responses are discarded if flagged stale or if a redirect hits this cycle.
    assign w_push_mem   = (r_state == S_WAIT) & imem_rvalid_i & ~r_drop & ~redirect_i;
    assign w_push       = w_push_fault | w_push_mem;
    assign w_push_instr = w_push_fault ? NOP_INSTR : imem_rdata_i;
    assign w_push_pc    = w_push_fault ? pc_i : r_addr;

    assign w_valid      = (r_count != '0);
    assign w_pop        = w_valid & instr_ready_i;

    // Next-state logic: redirect never changes state, it only marks the
    // outstanding response as stale.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_ack && w_aligned) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_gnt_i) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered memory request; the address is captured only on an aligned
    // ack, so it holds steady for the whole REQ phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req  <= 1'b0;
            r_addr <= '0;
        end else begin
            r_req <= (w_next_state == S_REQ);
            if (w_ack && w_aligned) begin
                r_addr <= {pc_i[31:2], 2'b00};
            end
        end
    end

    // Drop flag: marks the in-flight response as belonging to a flushed path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop <= 1'b0;
        end else if ((r_state == S_WAIT) && imem_rvalid_i) begin
            r_drop <= 1'b0;
        end else if (redirect_i && (r_state != S_IDLE)) begin
            r_drop <= 1'b1;
        end
    end

    // FIFO pointers and count; a redirect empties the FIFO outright.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are only visible through the valid-gated head.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_instr[r_wr_ptr] <= w_push_instr;
            r_fifo_pc[r_wr_ptr]    <= w_push_pc;
            r_fifo_fault[r_wr_ptr] <= w_push_fault;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc_ack_o      = w_ack;
    assign imem_req_o    = r_req;
    assign imem_addr_o   = r_addr;
    assign instr_valid_o = w_valid;
    assign instr_o       = w_valid ? r_fifo_instr[r_rd_ptr] : '0;
    assign instr_pc_o    = w_valid ? r_fifo_pc[r_rd_ptr]    : '0;
    assign instr_fault_o = w_valid ? r_fifo_fault[r_rd_ptr] : 1'b0;
    assign dbg_state_o   = r_state;

endmodule
